// File: rtl/turf_bus_pkg.sv
// Shared definitions for the TURF bus arbiter: FSM encoding, address width,
// and the read data returned on a forced completion.
package turf_bus_pkg;

    localparam int          TURF_ADDR_W          = 6;
    localparam logic [31:0] TIMEOUT_DATA_DEFAULT = 32'hDEADDEAD;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/turf_arb_timeout.sv
// Stall counter for the arbiter: counts enabled cycles and flags the
// TIMEOUT_CYCLES-th one. Only built when TURF_BUS_ARBITER_TIMEOUT_EN is defined.
module turf_arb_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] count;

    // The first enabled cycle sees count 0, so expiry lands on cycle TIMEOUT_CYCLES.
    assign expired = enable & (count == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/turf_bus_arbiter.sv
// Round-robin arbiter sharing the TURF register target between requesters a and b.
// Define TURF_BUS_ARBITER_TIMEOUT_EN to force completion of transactions the target never acks.
module turf_bus_arbiter
    import turf_bus_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_DATA   = TIMEOUT_DATA_DEFAULT
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   ma_wr_i,
    input  logic                   ma_rd_i,
    input  logic [TURF_ADDR_W-1:0] ma_addr_i,
    input  logic [31:0]            ma_dat_i,
    output logic [31:0]            ma_dat_o,
    output logic                   ma_ack_o,
    input  logic                   mb_wr_i,
    input  logic                   mb_rd_i,
    input  logic [TURF_ADDR_W-1:0] mb_addr_i,
    input  logic [31:0]            mb_dat_i,
    output logic [31:0]            mb_dat_o,
    output logic                   mb_ack_o,
    output logic                   turf_wr_o,
    output logic                   turf_rd_o,
    output logic [TURF_ADDR_W-1:0] turf_addr_o,
    output logic [31:0]            turf_dat_o,
    input  logic [31:0]            turf_dat_i,
    input  logic                   turf_ack_i,
    output logic                   grant_o,
    output logic                   busy_o,
    output logic                   timeout_o
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("turf_bus_arbiter: TIMEOUT_CYCLES must be in 2..65535");
    end

    arb_state_t             state;
    logic                   last_grant;
    logic                   req_a;
    logic                   req_b;
    logic                   pick_b;
    logic                   sel_wr;
    logic                   sel_rd;
    logic [TURF_ADDR_W-1:0] sel_addr;
    logic [31:0]            sel_dat;
    logic                   active;
    logic                   forced;
    logic                   done;
    logic [31:0]            rsp_data;

    assign req_a  = ma_wr_i | ma_rd_i;
    assign req_b  = mb_wr_i | mb_rd_i;
    // On a tie b wins only if a was granted last; last_grant resets to b so a wins first.
    assign pick_b = req_b & (~req_a | ~last_grant);

    assign sel_wr   = pick_b ? mb_wr_i   : ma_wr_i;
    assign sel_rd   = pick_b ? mb_rd_i   : ma_rd_i;
    assign sel_addr = pick_b ? mb_addr_i : ma_addr_i;
    assign sel_dat  = pick_b ? mb_dat_i  : ma_dat_i;

    assign active = (state == ST_ACTIVE);

`ifdef TURF_BUS_ARBITER_TIMEOUT_EN
    logic expired;

    turf_arb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk_i),
        .rst_n  (rst_n_i),
        .clear  (~active),
        .enable (active),
        .expired(expired)
    );

    // A real ack on the expiry cycle wins over the forced completion.
    assign forced = expired & ~turf_ack_i;
`else
    assign forced    = 1'b0;
    assign timeout_o = 1'b0;
`endif

    assign done     = active & (turf_ack_i | forced);
    assign rsp_data = forced ? TIMEOUT_DATA : turf_dat_i;

    // Acks are combinational so they land in the target's ack cycle; reset kills them at once.
    assign ma_ack_o = rst_n_i & done & ~grant_o;
    assign mb_ack_o = rst_n_i & done &  grant_o;
    assign ma_dat_o = rsp_data;
    assign mb_dat_o = rsp_data;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state       <= ST_IDLE;
            turf_wr_o   <= 1'b0;
            turf_rd_o   <= 1'b0;
            turf_addr_o <= '0;
            turf_dat_o  <= '0;
            grant_o     <= 1'b0;
            busy_o      <= 1'b0;
            last_grant  <= 1'b1;
`ifdef TURF_BUS_ARBITER_TIMEOUT_EN
            timeout_o   <= 1'b0;
`endif
        end else begin
`ifdef TURF_BUS_ARBITER_TIMEOUT_EN
            timeout_o <= forced;
`endif
            case (state)
                ST_IDLE: begin
                    if (req_a || req_b) begin
                        state       <= ST_ACTIVE;
                        busy_o      <= 1'b1;
                        grant_o     <= pick_b;
                        last_grant  <= pick_b;
                        turf_addr_o <= sel_addr;
                        turf_dat_o  <= sel_dat;
                        turf_wr_o   <= sel_wr;
                        turf_rd_o   <= sel_rd & ~sel_wr;
                    end
                end
                ST_ACTIVE: begin
                    if (done) begin
                        state     <= ST_RELEASE;
                        turf_wr_o <= 1'b0;
                        turf_rd_o <= 1'b0;
                    end
                end
                ST_RELEASE: begin
                    // One dead cycle lets the acked requester drop its level request.
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/turf_bus_arbiter.md
TURF_BUS_ARBITER -- requirements
Module: turf_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, which is the number of cycles in ACTIVE without turf_ack_i before a forced completion (range 2..65535).
REQ-002 SHALL have parameter TIMEOUT_DATA, default 32'hDEADDEAD, which is the read data returned on a forced completion.
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 SHALL have port rst_n_i, input, 1 bit: synchronous active-low reset.
REQ-006 SHALL have, for each requester N in {a,b}, ports mN_wr_i (in, 1), mN_rd_i (in, 1), mN_addr_i (in, 6), mN_dat_i (in, 32): a level request held until acked; requester a is the PLX TURF port.
REQ-007 SHALL have, for each requester N, port mN_dat_o, output, 32 bits: read data, valid when mN_ack_o is high.
REQ-008 SHALL have, for each requester N, port mN_ack_o, output, 1 bit: one-cycle completion pulse.
REQ-009 SHALL have ports turf_wr_o (out, 1), turf_rd_o (out, 1), turf_addr_o (out, 6), turf_dat_o (out, 32): registered target strobes, address and data.
REQ-010 SHALL have ports turf_dat_i (in, 32) and turf_ack_i (in, 1): target read data and completion.
REQ-011 SHALL have port grant_o, output, 1 bit: 0 = requester a owns the target, 1 = requester b owns it; valid while busy_o is high.
REQ-012 SHALL have port busy_o, output, 1 bit: high in the ACTIVE and RELEASE states.
REQ-013 SHALL have port timeout_o, output, 1 bit: one-cycle pulse on each forced completion.

Function
REQ-014 SHALL implement the states IDLE, ACTIVE and RELEASE.
REQ-015 SHALL, in IDLE, move to ACTIVE when any (mN_wr_i|mN_rd_i) is high, latching grant, address, data and direction.
REQ-016 SHALL, when both requesters request in the same cycle, grant the requester not granted last (round-robin); after reset, a wins first.
REQ-017 SHALL assert turf_wr_o or turf_rd_o on the cycle after the request is sampled in IDLE, and hold it through ACTIVE.
REQ-018 SHALL, when wr and rd are both high from one requester, perform a write.
REQ-019 SHALL drive ack and data combinationally: mN_ack_o = ACTIVE & grant==N & turf_ack_i, and mN_dat_o = turf_dat_i, so the ack lands in the same cycle as turf_ack_i.
REQ-020 SHALL keep the non-granted requester's mN_ack_o at 0 at all times.
REQ-021 SHALL, on ack in ACTIVE, go to RELEASE; turf_wr_o and turf_rd_o drop on that same edge.
REQ-022 SHALL ignore all requests in RELEASE (one cycle, giving the requester time to deassert), then return to IDLE.
REQ-023 SHALL ignore turf_ack_i in IDLE and RELEASE, generating no mN_ack_o.
REQ-024 SHALL keep the latched turf_addr_o and turf_dat_o stable from the grant until leaving ACTIVE, even if the requester's inputs change.
REQ-025 SHALL give a minimum back-to-back transaction period of 3 cycles plus the target latency.

Reset
REQ-026 SHALL, while rst_n_i is low at a clock edge, set state IDLE, turf_wr_o=0, turf_rd_o=0, turf_addr_o=0, turf_dat_o=0, grant_o=0, busy_o=0, timeout_o=0, last-grant=b and the timeout counter to 0.
REQ-027 SHALL force mN_ack_o to 0 whenever rst_n_i is low, including during a reset asserted mid-ACTIVE; such a transaction is abandoned without an ack.

Configuration
REQ-028 SHALL, with macro TURF_BUS_ARBITER_TIMEOUT_EN defined, count cycles in ACTIVE; when the count reaches TIMEOUT_CYCLES with no turf_ack_i, it SHALL pulse mN_ack_o for the granted requester with mN_dat_o=TIMEOUT_DATA, pulse timeout_o, and go to RELEASE.
REQ-029 SHALL, when turf_ack_i coincides with the timeout cycle, treat the event as a normal ack, with no timeout_o and turf_dat_i returned.
REQ-030 SHALL, with TURF_BUS_ARBITER_TIMEOUT_EN undefined, have no counter, wait in ACTIVE indefinitely, and tie timeout_o to 0.

Structure
REQ-031 SHALL place the state encoding (2 bits: IDLE=0, ACTIVE=1, RELEASE=2), the TURF address width (6) and the default TIMEOUT_DATA in shared package turf_bus_pkg.
REQ-032 SHALL implement the timeout counter as sub-module turf_arb_timeout (clear/enable/expired), instantiated only under TURF_BUS_ARBITER_TIMEOUT_EN.

Verification
REQ-033 SHALL cover: a write from a only, addr 6'h05, data 32'h12345678, target acks 3 cycles after strobe -> turf_wr_o high for 3 cycles with addr 05/data 12345678, ma_ack_o one pulse, mb_ack_o stays 0.
REQ-034 SHALL cover: a and b both issue reads in the same cycle right after reset -> a is served first, then b; grant_o goes 0 then 1; each gets its own turf_dat_i value (32'hA5A5A5A5, 32'h5A5A5A5A).
REQ-035 SHALL cover: a requests continuously while b requests once -> grants alternate a, b, a; there is at least one idle cycle (busy_o=0) between transactions.
REQ-036 SHALL cover: with TIMEOUT_EN and TIMEOUT_CYCLES=4, a read with the target never acking -> mb_ack_o pulses with data 32'hDEADDEAD, timeout_o pulses once, and the strobe drops.
REQ-037 SHALL cover: with TIMEOUT_EN, turf_ack_i on exactly the 4th ACTIVE cycle -> a normal ack with turf_dat_i data and timeout_o=0.
REQ-038 SHALL cover: rst_n_i pulled low for 1 cycle mid-ACTIVE -> no ack, strobes 0 on the next edge, and a request re-issued afterwards completes normally with grant to a.
